// File: rtl/oven_pkg.sv
// Shared types and helpers for the oven controller: state codes, display modes
// and the binary-to-BCD display conversions.
package oven_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_SET     = 3'd1,
        ST_PREHEAT = 3'd2,
        ST_BAKE    = 3'd3,
        ST_DONE    = 3'd4
    } oven_state_e;

    typedef enum logic [1:0] {
        DISP_CLOCK,
        DISP_TARGET,
        DISP_TEMP,
        DISP_BAKE
    } disp_mode_e;

    // Wall clock wraps 59:59 -> 00:00.
    localparam int WALL_SECS = 3600;

    function automatic int clamp_int(input int value, input int lo, input int hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

    // Seconds to {M tens, M units, S tens, S units}.
    function automatic logic [15:0] sec_to_mmss(input logic [15:0] secs);
        int mm;
        int ss;
        mm = int'(secs) / 60;
        ss = int'(secs) % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // Temperature to {0, hundreds, tens, units}.
    function automatic logic [15:0] temp_to_bcd(input logic [15:0] temp);
        int t;
        t = int'(temp);
        return {4'd0, 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
    endfunction

endpackage

// File: rtl/oven_tick_gen.sv
// Clock divider producing a one-cycle simulation tick every CLK_HZ/TICK_HZ
// cycles; the first tick appears that many cycles after reset release.
module oven_tick_gen #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_q <= '0;
            tick  <= 1'b1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/oven_ctrl_fsm.sv
// Oven controller: wall clock, button-driven target/bake entry, preheat/bake
// state machine with thermostat, done alarm and four-digit BCD display mux.
module oven_ctrl_fsm
    import oven_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TICK_HZ      = 1,
    parameter int TEMP_W       = 11,
    parameter int AMBIENT      = 60,
    parameter int TEMP_MIN     = 60,
    parameter int TEMP_MAX     = 900,
    parameter int TEMP_STEP    = 10,
    parameter int TEMP_DEFAULT = 300,
    parameter int TEMP_TOL     = 5,
    parameter int HEAT_RATE    = 2,
    parameter int COOL_RATE    = 1,
    parameter int TIME_MAX     = 3600,
    parameter int TIME_STEP    = 60
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwr_en,
    input  logic              time_sel,
    input  logic              up_btn,
    input  logic              dn_btn,
    input  logic              start_btn,
    output logic              heat_on,
    output logic              done,
    output logic [2:0]        state,
    output logic [TEMP_W-1:0] temp_now,
    output logic [3:0]        dig3,
    output logic [3:0]        dig2,
    output logic [3:0]        dig1,
    output logic [3:0]        dig0
);

    localparam int TIME_W = $clog2(TIME_MAX + 1);
    localparam int WALL_W = $clog2(WALL_SECS);

    logic              tick;
    logic              up_q, dn_q, start_q;
    logic              up_edge, dn_edge, start_edge;
    logic              adj_inc, adj_dec;
    int                temp_delta, time_delta;

    oven_state_e       state_q;
    logic [TEMP_W-1:0] target_q, temp_q;
    logic [TIME_W-1:0] bake_q;
    logic [WALL_W-1:0] wall_q;
    logic              heat_q, done_q;
    logic [15:0]       disp_q;

    logic [TEMP_W-1:0] temp_heat, temp_cool, target_adj;
    logic [TIME_W-1:0] bake_adj, bake_dec, bake_run;
    logic              preheat_hit;
    disp_mode_e        disp_mode;
    logic [15:0]       disp_next;

    oven_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            up_q    <= up_btn;
            dn_q    <= dn_btn;
            start_q <= start_btn;
        end
    end

    assign up_edge    = up_btn & ~up_q;
    assign dn_edge    = dn_btn & ~dn_q;
    assign start_edge = start_btn & ~start_q;
    // Opposite edges in the same cycle cancel.
    assign adj_inc    = up_edge & ~dn_edge;
    assign adj_dec    = dn_edge & ~up_edge;

    // NOTE: every variable gets a value on every path through this block, so
    // no latch is inferred.
    always_comb begin
        temp_delta  = adj_inc ? TEMP_STEP : (adj_dec ? -TEMP_STEP : 0);
        time_delta  = adj_inc ? TIME_STEP : (adj_dec ? -TIME_STEP : 0);
        temp_heat   = TEMP_W'(clamp_int(int'(temp_q) + HEAT_RATE, AMBIENT, TEMP_MAX));
        temp_cool   = TEMP_W'(clamp_int(int'(temp_q) - COOL_RATE, AMBIENT, TEMP_MAX));
        target_adj  = TEMP_W'(clamp_int(int'(target_q) + temp_delta, TEMP_MIN, TEMP_MAX));
        bake_adj    = TIME_W'(clamp_int(int'(bake_q) + time_delta, 0, TIME_MAX));
        bake_dec    = tick ? TIME_W'(clamp_int(int'(bake_q) - 1, 0, TIME_MAX)) : bake_q;
        // During bake the tick decrement lands before the button adjustment.
        bake_run    = time_sel ? TIME_W'(clamp_int(int'(bake_dec) + time_delta, 0, TIME_MAX))
                               : bake_dec;
        preheat_hit = (int'(temp_heat) + TEMP_TOL) >= int'(target_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wall_q <= '0;
        end else if (tick) begin
            wall_q <= (wall_q == WALL_W'(WALL_SECS - 1)) ? '0 : wall_q + WALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            target_q <= TEMP_W'(TEMP_DEFAULT);
            temp_q   <= TEMP_W'(AMBIENT);
            bake_q   <= '0;
            heat_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (!pwr_en) begin
            state_q <= ST_OFF;
            bake_q  <= '0;
            heat_q  <= 1'b0;
            done_q  <= 1'b0;
            if (tick) temp_q <= temp_cool;
        end else begin
            case (state_q)
                ST_OFF: begin
                    heat_q  <= 1'b0;
                    state_q <= ST_SET;
                    if (tick) temp_q <= temp_cool;
                end
                ST_SET: begin
                    if (time_sel) bake_q <= bake_adj;
                    else          target_q <= target_adj;
                    if (tick) temp_q <= temp_cool;
                    if (start_edge && bake_q != '0) begin
                        state_q <= ST_PREHEAT;
                        heat_q  <= 1'b1;
                    end
                end
                ST_PREHEAT: begin
                    heat_q <= 1'b1;
                    if (!time_sel) target_q <= target_adj;
                    if (tick) begin
                        temp_q <= temp_heat;
                        if (preheat_hit) begin
                            state_q <= ST_BAKE;
                            heat_q  <= (temp_heat < target_q);
                        end
                    end
                end
                ST_BAKE: begin
                    if (tick) begin
                        if (temp_q < target_q) begin
                            heat_q <= 1'b1;
                            temp_q <= temp_heat;
                        end else begin
                            heat_q <= 1'b0;
                            temp_q <= temp_cool;
                        end
                    end
                    bake_q <= bake_run;
                    if (!time_sel) target_q <= target_adj;
                    if (bake_run == '0) begin
                        state_q <= ST_DONE;
                        heat_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    heat_q <= 1'b0;
                    done_q <= 1'b1;
                    if (tick) temp_q <= temp_cool;
                    if (start_edge) begin
                        state_q <= ST_SET;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_OFF;
                    heat_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // DONE shares the bake view: bake is always zero there, giving 00:00.
    always_comb begin
        disp_mode = DISP_BAKE;
        case (state_q)
            ST_OFF:     disp_mode = DISP_CLOCK;
            ST_SET:     disp_mode = time_sel ? DISP_BAKE : DISP_TARGET;
            ST_PREHEAT: disp_mode = DISP_TEMP;
            default:    disp_mode = DISP_BAKE;
        endcase

        disp_next = '0;
        case (disp_mode)
            DISP_CLOCK:  disp_next = sec_to_mmss(16'(wall_q));
            DISP_TARGET: disp_next = temp_to_bcd(16'(target_q));
            DISP_TEMP:   disp_next = temp_to_bcd(16'(temp_q));
            default:     disp_next = sec_to_mmss(16'(bake_q));
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) disp_q <= '0;
        else        disp_q <= disp_next;
    end

    assign state    = state_q;
    assign heat_on  = heat_q;
    assign done     = done_q;
    assign temp_now = temp_q;
    assign {dig3, dig2, dig1, dig0} = disp_q;

endmodule

// File: tb/tb_oven_ctrl_fsm.sv
// Directed plus randomized bench for oven_ctrl_fsm, compared every cycle against
// an integer reference model of the oven's behaviour.
module tb_oven_ctrl_fsm;

    localparam int DIV     = 10;
    localparam int AMB     = 60;
    localparam int T_MIN   = 60;
    localparam int T_MAX   = 900;
    localparam int T_STEP  = 10;
    localparam int T_TOL   = 5;
    localparam int HEAT    = 2;
    localparam int COOL    = 1;
    localparam int B_MAX   = 3600;
    localparam int B_STEP  = 60;

    logic        clk = 1'b0;
    logic        rst_n, pwr_en, time_sel, up_btn, dn_btn, start_btn;
    logic        heat_on, done;
    logic [2:0]  state;
    logic [10:0] temp_now;
    logic [3:0]  dig3, dig2, dig1, dig0;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model, plain integers.
    int m_state, m_target, m_temp, m_bake, m_wall, m_heat, m_done, m_disp, m_cyc;
    bit m_up_q, m_dn_q, m_st_q;

    oven_ctrl_fsm #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwr_en   (pwr_en),
        .time_sel (time_sel),
        .up_btn   (up_btn),
        .dn_btn   (dn_btn),
        .start_btn(start_btn),
        .heat_on  (heat_on),
        .done     (done),
        .state    (state),
        .temp_now (temp_now),
        .dig3     (dig3),
        .dig2     (dig2),
        .dig1     (dig1),
        .dig0     (dig0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int lim(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int mmss(input int v);
        int mm = v / 60;
        int ss = v % 60;
        return (mm / 10) * 4096 + (mm % 10) * 256 + (ss / 10) * 16 + ss % 10;
    endfunction

    function automatic int hundreds(input int t);
        return ((t / 100) % 10) * 256 + ((t / 10) % 10) * 16 + t % 10;
    endfunction

    function automatic int show(input int st, input bit tsel);
        case (st)
            0:       return mmss(m_wall);
            1:       return tsel ? mmss(m_bake) : hundreds(m_target);
            2:       return hundreds(m_temp);
            default: return mmss(m_bake);
        endcase
    endfunction

    function automatic bit tick_next();
        return (m_cyc > 0) && (m_cyc % DIV == 0);
    endfunction

    task automatic model_reset();
        m_state = 0; m_target = 300; m_temp = AMB; m_bake = 0; m_wall = 0;
        m_heat = 0; m_done = 0; m_disp = 0; m_cyc = 0;
        m_up_q = 0; m_dn_q = 0; m_st_q = 0;
    endtask

    // One rising edge of the model, using the inputs currently applied.
    task automatic model_edge();
        bit tk, ue, de, se;
        int dt, db, tgt;
        tk = tick_next();
        m_cyc++;
        m_disp = show(m_state, time_sel);
        ue = up_btn && !m_up_q;
        de = dn_btn && !m_dn_q;
        se = start_btn && !m_st_q;
        m_up_q = up_btn; m_dn_q = dn_btn; m_st_q = start_btn;
        dt = (ue && !de) ? T_STEP : ((de && !ue) ? -T_STEP : 0);
        db = (ue && !de) ? B_STEP : ((de && !ue) ? -B_STEP : 0);
        tgt = m_target;
        if (tk) m_wall = (m_wall + 1) % 3600;
        if (!pwr_en) begin
            m_state = 0; m_bake = 0; m_done = 0; m_heat = 0;
            if (tk) m_temp = lim(m_temp - COOL, AMB, T_MAX);
        end else begin
            case (m_state)
                0: begin
                    m_heat = 0; m_state = 1;
                    if (tk) m_temp = lim(m_temp - COOL, AMB, T_MAX);
                end
                1: begin
                    if (se && m_bake > 0) begin m_state = 2; m_heat = 1; end
                    if (time_sel) m_bake = lim(m_bake + db, 0, B_MAX);
                    else m_target = lim(m_target + dt, T_MIN, T_MAX);
                    if (tk) m_temp = lim(m_temp - COOL, AMB, T_MAX);
                end
                2: begin
                    if (!time_sel) m_target = lim(m_target + dt, T_MIN, T_MAX);
                    if (tk) begin
                        m_temp = lim(m_temp + HEAT, AMB, T_MAX);
                        if (m_temp >= tgt - T_TOL) begin
                            m_state = 3; m_heat = (m_temp < tgt);
                        end
                    end
                end
                3: begin
                    if (tk) begin
                        if (m_temp < tgt) begin m_heat = 1; m_temp = lim(m_temp + HEAT, AMB, T_MAX); end
                        else begin m_heat = 0; m_temp = lim(m_temp - COOL, AMB, T_MAX); end
                        m_bake = lim(m_bake - 1, 0, B_MAX);
                    end
                    if (time_sel) m_bake = lim(m_bake + db, 0, B_MAX);
                    else m_target = lim(m_target + dt, T_MIN, T_MAX);
                    if (m_bake == 0) begin m_state = 4; m_heat = 0; m_done = 1; end
                end
                default: begin
                    m_heat = 0; m_done = 1;
                    if (tk) m_temp = lim(m_temp - COOL, AMB, T_MAX);
                    if (se) begin m_state = 1; m_done = 0; end
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("state", state, m_state);
        check("heat_on", heat_on, m_heat);
        check("done", done, m_done);
        check("temp_now", temp_now, m_temp);
        check("digits", {dig3, dig2, dig1, dig0}, m_disp);
    endtask

    task automatic press(input logic u, input logic d, input logic s);
        up_btn = u; dn_btn = d; start_btn = s;
        step();
        up_btn = 0; dn_btn = 0; start_btn = 0;
        step();
    endtask

    task automatic wait_bake();
        for (int i = 0; i < 3000 && state !== 3'd3; i++) step();
        check("reach_bake", state, 3);
    endtask

    initial begin
        int tmin, tmax;
        bit saw_heat, saw_idle;

        rst_n = 0; pwr_en = 0; time_sel = 0; up_btn = 0; dn_btn = 0; start_btn = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_temp", temp_now, 60);
        check("rst_digits", {dig3, dig2, dig1, dig0}, 16'h0000);
        check("rst_heat", heat_on, 0);
        check("rst_done", done, 0);
        rst_n = 1;

        // Wall clock in OFF: 610 ticks shows 10:10.
        repeat (6105) step();
        check("wall_1010", {dig3, dig2, dig1, dig0}, 16'h1010);

        // Asynchronous reset between edges.
        #2 rst_n = 0;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_digits", {dig3, dig2, dig1, dig0}, 16'h0000);
        model_reset();
        @(negedge clk);
        rst_n = 1;

        pwr_en = 1;
        step();
        check("to_set", state, 1);
        repeat (70) press(1, 0, 0);
        check("target_max", {dig3, dig2, dig1, dig0}, 16'h0900);
        press(1, 1, 0);
        check("target_cancel", {dig3, dig2, dig1, dig0}, 16'h0900);
        repeat (90) press(0, 1, 0);
        check("target_min", {dig3, dig2, dig1, dig0}, 16'h0060);
        press(1, 0, 0);
        check("target_70", {dig3, dig2, dig1, dig0}, 16'h0070);

        time_sel = 1;
        step();
        repeat (2) press(1, 0, 0);
        check("bake_120", {dig3, dig2, dig1, dig0}, 16'h0200);
        start_btn = 1;
        step();
        check("preheat_state", state, 2);
        check("preheat_heat", heat_on, 1);
        start_btn = 0;
        wait_bake();
        check("bake_entry_temp", temp_now, 66);

        // Thermostat oscillation until the bake time runs out.
        tmin = 9999; tmax = 0; saw_heat = 0; saw_idle = 0;
        for (int i = 0; i < 1500 && state === 3'd3; i++) begin
            if (temp_now < tmin) tmin = temp_now;
            if (temp_now > tmax) tmax = temp_now;
            if (heat_on === 1'b1) saw_heat = 1;
            if (heat_on === 1'b0) saw_idle = 1;
            step();
        end
        check("done_state", state, 4);
        check("done_flag", done, 1);
        check("done_heat", heat_on, 0);
        check("thermo_heated", saw_heat, 1);
        check("thermo_idled", saw_idle, 1);
        check("thermo_hi", tmax <= 72, 1);
        check("thermo_lo", tmin >= 66, 1);
        step();
        check("done_digits", {dig3, dig2, dig1, dig0}, 16'h0000);

        start_btn = 1;
        step();
        check("done_to_set", state, 1);
        check("done_cleared", done, 0);
        start_btn = 0;
        step();
        press(0, 0, 1);
        repeat (3) step();
        check("start_bake0_ignored", state, 1);

        // Tick and down edge together with 30 s left clamps to zero.
        press(1, 0, 0);
        press(0, 0, 1);
        wait_bake();
        for (int i = 0; i < 2000 && !(m_bake == 30 && tick_next()); i++) step();
        check("bake30_reached", m_bake, 30);
        dn_btn = 1;
        step();
        dn_btn = 0;
        check("tick_dn_done", state, 4);
        check("tick_dn_flag", done, 1);

        // Power loss during bake.
        press(0, 0, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        wait_bake();
        repeat (15) step();
        pwr_en = 0;
        step();
        check("pwr_off_state", state, 0);
        check("pwr_off_heat", heat_on, 0);
        pwr_en = 1;
        step();
        step();
        check("pwr_bake_cleared", {dig3, dig2, dig1, dig0}, 16'h0000);
        time_sel = 0;
        step();
        check("pwr_target_kept", {dig3, dig2, dig1, dig0}, 16'h0070);

        // Randomized operation against the model.
        for (int i = 0; i < 4000; i++) begin
            pwr_en    = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 49) == 0) time_sel = ~time_sel;
            up_btn    = ($urandom_range(0, 3) == 0);
            dn_btn    = ($urandom_range(0, 3) == 0);
            start_btn = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
